// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and stall controller for a five-stage in-order pipeline.
//
// Generates the register load enables and the NOP-insertion controls for the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three cases:
//   * data-memory wait: the front of the pipe freezes while MEM stalls;
//     bubbles are fed into WB, and a timeout leads to HALT;
//   * taken branch resolved in EX: the IF/ID and ID/EX contents are flushed;
//   * load-use hazard: the PC and IF/ID are held and a bubble enters EX.
// Priority: memory freeze > branch flush > load-use.
//
// Parameters
//   MEM_TIMEOUT   maximum number of MEM_WAIT cycles before HALT (2..255)
// Optional feature
//   PIPE_CTRL_PERF_EN  when defined, adds the saturating performance counters
//                      stall_cycles and flush_count
//
// Ports
//   clock, reset_n                 clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2    source registers used by the ID instruction
//   ex_mem_read, ex_rd             load flag and destination of the EX instruction
//   ex_branch_taken                branch/jump resolved taken in EX
//   mem_req, mem_ready             MEM-stage access request and completion
//   pc_en .. mem_wb_en             pipeline register load enables
//   if_id_flush, id_ex_flush,
//   mem_wb_bubble                  load a NOP into that register
//   state                          RUN=0, MEM_WAIT=1, HALT=2
//   halt_err                       sticky memory timeout flag
//   stall_cycles, flush_count      (PIPE_CTRL_PERF_EN only) performance counters
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_bubble,
  output logic [1:0] state,
  output logic       halt_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       halt_err_q, halt_err_d;

  logic freeze;
  logic load_use;

  // A pending memory access freezes everything upstream of MEM.
  assign freeze = ((state_q == RUN) && mem_req && !mem_ready) ||
                  ((state_q == MEM_WAIT) && !mem_ready);

  // Register x0 is hard-wired to zero, so a load into it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      halt_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halt_err_q <= halt_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    halt_err_d = halt_err_q;
    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HALT;
          halt_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HALT: begin
        // Only reset leaves HALT.
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset_n) begin
      // Hold everything and keep NOPs in the pipe while reset is asserted.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state_q == HALT) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (freeze) begin
      // WB keeps draining; it receives bubbles until MEM completes.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign state    = state_q;
  assign halt_err = halt_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (!pc_en && (state_q != HALT) && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (if_id_flush && (state_q != HALT) && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
